// File: rtl/operand_sequencer_pkg.sv
// Shared encodings and sizing for the operand sequencer and its key debouncer.
package operand_sequencer_pkg;

  localparam int unsigned OPERAND_W               = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_e;

endpackage

// File: rtl/operand_sequencer_key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted high-to-low transition of the debounced level.
module key_debounce
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             key_db_q, key_db_d;
  logic             key_db_prev_q, key_db_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // The counter only survives while the synchronized level disagrees with the
  // accepted level; any agreeing cycle restarts the stability window.
  always_comb begin
    s1_d          = key_n;
    s2_d          = s1_q;
    key_db_d      = key_db_q;
    cnt_d         = '0;
    key_db_prev_d = key_db_q;
    press_d       = key_db_prev_q & ~key_db_q;
    if (s2_q != key_db_q) begin
      if (cnt_q == CNT_LAST) begin
        key_db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      cnt_q         <= '0;
      press_q       <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_prev_d;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/operand_sequencer.sv
// Captures two switch operands on successive key presses and presents them as
// a coherent pair to a downstream adder.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 key_n,
  input  logic [OPERAND_W-1:0] switch,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 valid,
  output logic [1:0]           phase
);

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic                 valid_q, valid_d;
  logic                 press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_n),
    .press  (press)
  );

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  // Next state; SHOW loops straight back to LOAD_B, the unused code recovers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (press) state_d = LOAD_B;
      LOAD_B:  if (press) state_d = SHOW;
      SHOW:    if (press) state_d = LOAD_B;
      default: state_d = LOAD_A;
    endcase
  end

  // Operand updates happen only on a press, on the same edge as the transition.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    case (state_q)
      LOAD_A: begin
        valid_d = 1'b0;
        if (press) begin
          a_d = switch;
          b_d = '0;
        end
      end
      LOAD_B: begin
        if (press) begin
          b_d     = switch;
          valid_d = 1'b1;
        end
      end
      SHOW: begin
        if (press) begin
          a_d     = switch;
          b_d     = '0;
          valid_d = 1'b0;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign phase = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench: stimulus queues the expected output change and the cycle it
// must appear on; a negedge monitor compares every observed output change.
module tb_operand_sequencer;
  import operand_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_n;
  logic [2:0] switch;
  logic [2:0] a, b;
  logic       valid;
  logic [1:0] phase;

  typedef struct {
    int         cyc;
    logic [2:0] a;
    logic [2:0] b;
    logic       v;
    logic [1:0] ph;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       mon_en = 1'b0;
  logic [8:0] prev;

  operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_n),
    .switch (switch),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .phase  (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of {a,b,valid,phase} must match the next queued entry.
  always @(negedge clk) begin
    if (mon_en && ({a, b, valid, phase} !== prev)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got a=%0d b=%0d valid=%0d phase=%0d, required no change",
                 cyc, a, b, valid, phase);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc || a !== e.a || b !== e.b || valid !== e.v || phase !== e.ph) begin
          failures++;
          $display("FAIL output_change got cyc=%0d a=%0d b=%0d valid=%0d phase=%0d, required cyc=%0d a=%0d b=%0d valid=%0d phase=%0d",
                   cyc, a, b, valid, phase, e.cyc, e.a, e.b, e.v, e.ph);
        end
      end
      prev = {a, b, valid, phase};
    end
  end

  task automatic at_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [2:0] ea, input logic [2:0] eb,
                      input logic ev, input logic [1:0] eph);
    exp_t e;
    e.cyc = c; e.a = ea; e.b = eb; e.v = ev; e.ph = eph;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    key_n   = 1'b1;
    switch  = 3'd0;

    at_edge(2);
    check("reset_a", int'(a), 0);
    check("reset_b", int'(b), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_phase", int'(phase), 0);
    reset_n = 1'b1;
    prev    = {a, b, valid, phase};
    mon_en  = 1'b1;

    // First operand: key sampled low at edge 10, capture visible after edge 17.
    at_edge(9);
    key_n  = 1'b0;
    switch = 3'd5;
    push(17, 3'd5, 3'd0, 1'b0, 2'b01);
    at_edge(20);
    switch = 3'd2;
    at_edge(29);
    key_n = 1'b1;

    // Second operand completes the pair.
    at_edge(39);
    key_n  = 1'b0;
    switch = 3'd6;
    push(47, 3'd5, 3'd6, 1'b1, 2'b10);
    at_edge(48);
    check("sum_a_plus_b", int'(a) + int'(b), 11);
    at_edge(50);
    key_n = 1'b1;

    // Press from SHOW restarts with a new first operand.
    at_edge(59);
    key_n  = 1'b0;
    switch = 3'd7;
    push(67, 3'd7, 3'd0, 1'b0, 2'b01);
    at_edge(70);
    key_n = 1'b1;

    // Bounce: five 3-cycle lows must never be accepted.
    for (int i = 0; i < 5; i++) begin
      at_edge(80 + 6 * i);
      key_n  = 1'b0;
      switch = 3'(i);
      at_edge(83 + 6 * i);
      key_n = 1'b1;
    end
    at_edge(115);
    check("bounce_hold", int'({a, b, phase}), int'({3'd7, 3'd0, 2'b01}));

    at_edge(119);
    key_n  = 1'b0;
    switch = 3'd3;
    push(127, 3'd7, 3'd3, 1'b1, 2'b10);
    at_edge(130);
    key_n = 1'b1;

    // Illegal state code recovers to LOAD_A and drops valid on the next edge.
    at_edge(139);
    push(140, 3'd7, 3'd3, 1'b1, 2'b11);
    push(141, 3'd7, 3'd3, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    dut.state_q = state_e'(2'b11);

    at_edge(149);
    key_n  = 1'b0;
    switch = 3'd5;
    push(157, 3'd5, 3'd0, 1'b0, 2'b01);
    at_edge(160);
    key_n = 1'b1;

    // Key held through reset: zeros during reset, one capture afterwards.
    at_edge(169);
    key_n   = 1'b0;
    reset_n = 1'b0;
    switch  = 3'd4;
    push(170, 3'd0, 3'd0, 1'b0, 2'b00);
    at_edge(171);
    check("in_reset_outputs", int'({a, b, valid, phase}), 0);
    at_edge(172);
    reset_n = 1'b1;
    push(180, 3'd4, 3'd0, 1'b0, 2'b01);
    at_edge(182);
    switch = 3'd1;
    at_edge(190);
    key_n = 1'b1;

    at_edge(210);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable clk cycles needed to accept a key level change; legal range is 2..2^20.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit: synchronous active-low reset, sampled on rising clk.
REQ-004 Port key_n, input, 1 bit: raw asynchronous pushbutton, active-low (0 = pressed).
REQ-005 Port switch, input, 3 bits: unsigned operand value from the slide switches.
REQ-006 Port a, output, 3 bits: registered first operand to the downstream adder.
REQ-007 Port b, output, 3 bits: registered second operand to the downstream adder.
REQ-008 Port valid, output, 1 bit: high when a and b are both captured and form a coherent pair for the adder.
REQ-009 Port phase, output, 2 bits: current FSM state encoding, driven to status LEDs.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 Debounce: the counter SHALL clear on every cycle where s2 == key_db, and SHALL increment while they differ.
REQ-012 When s2 != key_db and the counter == DEBOUNCE_CYCLES-1, key_db SHALL take s2 and the counter SHALL clear.
REQ-013 press SHALL be a registered 1-cycle pulse, asserted on the cycle after key_db goes 1->0.
REQ-014 Holding the key any length of time SHALL produce exactly one press; release produces none.
REQ-015 A glitch or bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no press.
REQ-016 Latency: with key_n sampled low at edge k and held, press SHALL be high after edge k+2+D, and the operand update SHALL be visible after edge k+3+D (D = DEBOUNCE_CYCLES).
REQ-017 FSM states and phase encodings SHALL be: LOAD_A=2'b00, LOAD_B=2'b01, SHOW=2'b10; 2'b11 is illegal and SHALL recover to LOAD_A on the next edge.
REQ-018 In LOAD_A on press: a <= switch, b <= 0, next state LOAD_B.
REQ-019 In LOAD_B on press: b <= switch, valid <= 1, next state SHOW.
REQ-020 In SHOW on press: a <= switch, b <= 0, valid <= 0, next state LOAD_B; a new sequence starts without passing through LOAD_A.
REQ-021 With no press, all registers SHALL hold their values.
REQ-022 switch SHALL be sampled only at the capture edge; switch changes at any other time have no effect.
REQ-023 valid SHALL be 1 only in SHOW and SHALL change on the same edge as the state change.
REQ-024 a and b are unsigned 3-bit; the downstream 4-bit sum range is 0..14 and this block performs no arithmetic.

Reset
REQ-025 When reset_n is 0 at a rising edge, the following SHALL apply on that edge:
  - a=0, b=0, valid=0, phase=LOAD_A
  - s1=s2=1, key_db=1, counter=0, press=0
REQ-026 Reset SHALL dominate a simultaneous press.
REQ-027 If the key is held through reset deassertion, it SHALL produce exactly one press, D+3 edges after reset_n rises.

Structure
REQ-028 A shared package SHALL hold the state encodings (LOAD_A, LOAD_B, SHOW), the operand width constant (3), and the DEBOUNCE_CYCLES default.
REQ-029 Synchronizer, debounce counter and press pulse SHALL form one sub-module, key_debounce (ports clk, reset_n, key_n, press); the FSM and operand registers stay in operand_sequencer.

Verification (D=4)
REQ-030 Reset, then key_n low at edge 10 and held 20 cycles with switch=3'd5 -> a=5 after edge 17, phase=01, valid=0, and exactly one press.
REQ-031 Continue: release the key, switch=3'd6, press again -> b=6, valid=1, phase=10; the downstream sum displays 11.
REQ-032 In SHOW with switch=3'd7, press -> a=7, b=0, valid=0, phase=01 on the same edge.
REQ-033 key_n pulsed low for 3 cycles, 5 times, separated by 3 high cycles -> no press; a, b and phase unchanged.
REQ-034 Key held while reset_n is asserted mid-sequence (phase=01, a=5) -> all outputs 0 during reset; one press D+3 edges after reset_n rises captures switch into a.
REQ-035 Force the state to 2'b11 -> phase=00 and valid=0 after the next edge.
